// File: rtl/histo_packet_sender.sv
`default_nettype none
// ============================================================================
// Module      : histo_packet_sender
// Description : Readout sequencer between a histogram read port and a byte
//               stream. Once histo_done is seen in IDLE it walks every bin,
//               reads the 24-bit count one cycle after presenting the
//               address, and emits a packet:
//                   0xAA, 0x55, frame_id, {cnt[23:16], cnt[15:8], cnt[7:0]}
//                   per bin, csum
//               csum is the mod-256 sum of frame_id and every data byte.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               histo_done        - start request (sampled in IDLE only)
//               bin / data        - histogram read address / count (1-cycle
//                                   read latency)
//               tx_data/tx_valid/tx_ready - outgoing byte stream
//               busy, done        - packet in progress / end-of-packet pulse
//               frame_id          - ID of the current or next packet
//               overrun_cnt       - ignored histo_done cycles (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module histo_packet_sender #(
    parameter int NUM_BINS = 1024,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              histo_done,
    output logic [ADDR_W-1:0] bin,
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_id,
    output logic [7:0]        overrun_cnt
);

    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_hdr0  = 4'd1;
    localparam logic [3:0] c_st_hdr1  = 4'd2;
    localparam logic [3:0] c_st_fid   = 4'd3;
    localparam logic [3:0] c_st_fetch = 4'd4;
    localparam logic [3:0] c_st_latch = 4'd5;
    localparam logic [3:0] c_st_b2    = 4'd6;
    localparam logic [3:0] c_st_b1    = 4'd7;
    localparam logic [3:0] c_st_b0    = 4'd8;
    localparam logic [3:0] c_st_csum  = 4'd9;
    localparam logic [3:0] c_st_done  = 4'd10;

    localparam logic [ADDR_W-1:0] c_last_bin = ADDR_W'(NUM_BINS - 1);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        frame_id_q, frame_id_d;
    logic [7:0]        overrun_q, overrun_d;

    logic              w_xfer;
    logic [7:0]        w_cur_byte;

    assign w_xfer = tx_valid_q && tx_ready;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_st_idle;
            bin_q      <= '0;
            hold_q     <= '0;
            csum_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            frame_id_q <= '0;
            overrun_q  <= '0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            hold_q     <= hold_d;
            csum_q     <= csum_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            frame_id_q <= frame_id_d;
            overrun_q  <= overrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle:  if (histo_done) state_d = c_st_hdr0;
            c_st_hdr0:  if (w_xfer) state_d = c_st_hdr1;
            c_st_hdr1:  if (w_xfer) state_d = c_st_fid;
            c_st_fid:   if (w_xfer) state_d = c_st_fetch;
            c_st_fetch: state_d = c_st_latch;
            c_st_latch: state_d = c_st_b2;
            c_st_b2:    if (w_xfer) state_d = c_st_b1;
            c_st_b1:    if (w_xfer) state_d = c_st_b0;
            c_st_b0: begin
                if (w_xfer) begin
                    state_d = (bin_q == c_last_bin) ? c_st_csum : c_st_fetch;
                end
            end
            c_st_csum:  if (w_xfer) state_d = c_st_done;
            c_st_done:  state_d = c_st_idle;
            default:    state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        bin_d      = bin_q;
        hold_d     = hold_q;
        csum_d     = csum_q;
        tx_data_d  = tx_data_q;
        frame_id_d = frame_id_q;
        overrun_d  = overrun_q;

        // Byte currently offered in a checksummed state; summed on transfer.
        case (state_q)
            c_st_fid: w_cur_byte = frame_id_q;
            c_st_b2:  w_cur_byte = hold_q[23:16];
            c_st_b1:  w_cur_byte = hold_q[15:8];
            c_st_b0:  w_cur_byte = hold_q[7:0];
            default:  w_cur_byte = 8'h00;
        endcase

        if (state_q == c_st_idle && state_d == c_st_hdr0) begin
            csum_d = 8'h00;
        end else if (w_xfer) begin
            csum_d = csum_q + w_cur_byte;
        end

        // The read port answers one cycle after the address is registered.
        if (state_q == c_st_latch) begin
            hold_d = data;
        end

        if (state_q == c_st_b0 && state_d == c_st_fetch) begin
            bin_d = bin_q + 1'b1;
        end
        if (state_d == c_st_idle) begin
            bin_d = '0;
        end

        if (state_q == c_st_done) begin
            frame_id_d = frame_id_q + 8'd1;
        end

        if (histo_done && state_q != c_st_idle && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end

        // Outputs are registered, so they are derived from the next state.
        // In a stalled state every source below is unchanged, keeping
        // tx_data stable until the transfer.
        case (state_d)
            c_st_hdr0: tx_data_d = 8'hAA;
            c_st_hdr1: tx_data_d = 8'h55;
            c_st_fid:  tx_data_d = frame_id_q;
            c_st_b2:   tx_data_d = hold_d[23:16];
            c_st_b1:   tx_data_d = hold_q[15:8];
            c_st_b0:   tx_data_d = hold_q[7:0];
            c_st_csum: tx_data_d = csum_d;
            default:   tx_data_d = tx_data_q;
        endcase

        tx_valid_d = (state_d == c_st_hdr0) || (state_d == c_st_hdr1) ||
                     (state_d == c_st_fid)  || (state_d == c_st_b2)   ||
                     (state_d == c_st_b1)   || (state_d == c_st_b0)   ||
                     (state_d == c_st_csum);
        busy_d     = (state_d != c_st_idle);
        done_d     = (state_d == c_st_done);
    end

    assign bin         = bin_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_id    = frame_id_q;
    assign overrun_cnt = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_histo_packet_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_histo_packet_sender
// Description : Scoreboard bench. Expected packets are built from the
//               framing rules and queued when a packet is requested; monitor
//               processes pop and compare on each accepted byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histo_packet_sender;

    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        histo_done, histo_done_b;
    logic        tx_ready;
    logic        tx_ready_b;

    logic [2:0]  bin_a;
    logic [23:0] data_a;
    logic [7:0]  tx_data_a, frame_id_a, overrun_a;
    logic        tx_valid_a, busy_a, done_a;

    logic [0:0]  bin_b;
    logic [23:0] data_b;
    logic [7:0]  tx_data_b, frame_id_b, overrun_b;
    logic        tx_valid_b, busy_b, done_b;

    logic [23:0] mem_a [0:7];
    logic [23:0] mem_b [0:1];

    logic [7:0]  exp_q[$];
    logic [7:0]  exp_b[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pkt_bytes = 0;
    logic [7:0]  model_fid = 8'd0;
    logic        bin_b_bad = 1'b0;

    always #5 clk = ~clk;

    histo_packet_sender #(.NUM_BINS(NB), .ADDR_W(3), .DATA_W(24)) u_dut_a (
        .clk(clk), .rst(rst), .histo_done(histo_done), .bin(bin_a),
        .data(data_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready), .busy(busy_a), .done(done_a),
        .frame_id(frame_id_a), .overrun_cnt(overrun_a)
    );

    histo_packet_sender #(.NUM_BINS(1), .ADDR_W(1), .DATA_W(24)) u_dut_b (
        .clk(clk), .rst(rst), .histo_done(histo_done_b), .bin(bin_b),
        .data(data_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .busy(busy_b), .done(done_b),
        .frame_id(frame_id_b), .overrun_cnt(overrun_b)
    );

    // Synchronous histogram read ports: one cycle of latency.
    always @(posedge clk) begin
        data_a <= mem_a[bin_a];
        data_b <= mem_b[bin_b];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference packet from the framing rules.
    task automatic push_packet(input logic [7:0] fid);
        logic [7:0]  s;
        logic [7:0]  by;
        logic [23:0] w;
        s = fid;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(fid);
        for (int b = 0; b < NB; b++) begin
            w = mem_a[b];
            for (int k = 2; k >= 0; k--) begin
                by = w[8*k +: 8];
                exp_q.push_back(by);
                s = s + by;
            end
        end
        exp_q.push_back(s);
    endtask

    // Monitor for DUT A: byte scoreboard plus stall-stability checks.
    logic        stall_pend = 1'b0;
    logic [7:0]  stall_data;
    logic [2:0]  stall_bin;
    always @(negedge clk) begin
        if (rst) begin
            stall_pend = 1'b0;
            pkt_bytes  = 0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", {31'd0, tx_valid_a}, 32'd1);
                check("stall_data_held", {24'd0, tx_data_a}, {24'd0, stall_data});
                check("stall_bin_held", {29'd0, bin_a}, {29'd0, stall_bin});
                stall_pend = 1'b0;
            end
            if (tx_valid_a && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, tx_data_a}, 32'hFFFF_FFFF);
                end else begin
                    check("byte", {24'd0, tx_data_a}, {24'd0, exp_q.pop_front()});
                end
                pkt_bytes++;
            end else if (tx_valid_a) begin
                stall_pend = 1'b1;
                stall_data = tx_data_a;
                stall_bin  = bin_a;
            end
            if (done_a) pkt_bytes = 0;
        end
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        if (!rst) begin
            if (bin_b != 1'b0) bin_b_bad = 1'b1;
            if (tx_valid_b && tx_ready_b) begin
                if (exp_b.size() == 0) begin
                    check("unexpected_byte_b", {24'd0, tx_data_b}, 32'hFFFF_FFFF);
                end else begin
                    check("byte_b", {24'd0, tx_data_b}, {24'd0, exp_b.pop_front()});
                end
            end
        end
    end

    task automatic start_packet();
        @(posedge clk); #1;
        histo_done = 1'b1;
        @(posedge clk); #1;
        histo_done = 1'b0;
        check("start_valid", {31'd0, tx_valid_a}, 32'd1);
        check("start_hdr", {24'd0, tx_data_a}, 32'hAA);
        check("start_busy", {31'd0, busy_a}, 32'd1);
    endtask

    // Cycles counted from the edge that raised tx_valid.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_a && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {31'd0, done_a}, 32'd1);
        check("done_busy", {31'd0, busy_a}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        model_fid = model_fid + 8'd1;
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done_a}, 32'd0);
        check("busy_fall", {31'd0, busy_a}, 32'd0);
    endtask

    logic [7:0] lit1 [16] = '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h01, 8'h02, 8'h03, 8'h02, 8'h04, 8'h06,
                              8'h03, 8'h06, 8'h09, 8'h24};
    logic [7:0] lit6 [7]  = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFD};

    initial begin
        int cyc;
        int hold;
        logic stalled;

        rst = 1'b1; histo_done = 1'b0; histo_done_b = 1'b0;
        tx_ready = 1'b1; tx_ready_b = 1'b1;
        for (int i = 0; i < 8; i++) mem_a[i] = 24'(i) * 24'h010203;
        mem_b[0] = 24'hFFFFFF;
        mem_b[1] = 24'h123456;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", {31'd0, tx_valid_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_data", {24'd0, tx_data_a}, 32'd0);
        check("rst_bin", {29'd0, bin_a}, 32'd0);
        check("rst_fid", {24'd0, frame_id_a}, 32'd0);
        check("rst_overrun", {24'd0, overrun_a}, 32'd0);

        // Known vector, then a second packet from the model.
        foreach (lit1[i]) exp_q.push_back(lit1[i]);
        start_packet();
        wait_done(cyc);
        check("pkt_cycles", cyc, 32'd24);
        push_packet(model_fid);
        start_packet();
        wait_done(cyc);
        check("pkt2_cycles", cyc, 32'd24);
        check("fid_after_two", {24'd0, frame_id_a}, 32'd2);

        // Random counts with random back-pressure and a 10-cycle B1 stall.
        for (int i = 0; i < NB; i++) mem_a[i] = 24'($urandom);
        push_packet(model_fid);
        start_packet();
        stalled = 1'b0; hold = 0; cyc = 0;
        while (!done_a && cyc < 5000) begin
            if (hold > 0) begin
                tx_ready = 1'b0;
                hold--;
            end else if (!stalled && pkt_bytes == 4) begin
                tx_ready = 1'b0;
                hold = 9;
                stalled = 1'b1;
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        tx_ready = 1'b1;
        check("stall_applied", {31'd0, stalled}, 32'd1);
        wait_done(cyc);

        // Three overrun pulses during one packet.
        for (int i = 0; i < NB; i++) mem_a[i] = 24'($urandom);
        push_packet(model_fid);
        start_packet();
        for (int p = 0; p < 3; p++) begin
            @(posedge clk); #1; histo_done = 1'b1;
            @(posedge clk); #1; histo_done = 1'b0;
        end
        wait_done(cyc);
        check("overrun_3", {24'd0, overrun_a}, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check("single_packet", {31'd0, busy_a}, 32'd0);

        // 300 overrun cycles saturate the counter.
        push_packet(model_fid);
        @(posedge clk); #1; histo_done = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        histo_done = 1'b0; tx_ready = 1'b1;
        wait_done(cyc);
        check("overrun_sat", {24'd0, overrun_a}, 32'd255);

        // Reset during bin 2, B1.
        for (int i = 0; i < NB; i++) mem_a[i] = 24'($urandom);
        push_packet(model_fid);
        start_packet();
        cyc = 0;
        while (pkt_bytes != 10 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reached_bin2_b1", pkt_bytes, 32'd10);
        tx_ready = 1'b0;
        rst = 1'b1;
        histo_done = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid", {31'd0, tx_valid_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_fid", {24'd0, frame_id_a}, 32'd0);
        check("mid_rst_overrun", {24'd0, overrun_a}, 32'd0);
        rst = 1'b0; histo_done = 1'b0; tx_ready = 1'b1;
        exp_q.delete();
        model_fid = 8'd0;
        @(posedge clk); #1;
        check("post_rst_idle", {31'd0, busy_a}, 32'd0);
        push_packet(model_fid);
        start_packet();
        wait_done(cyc);
        check("post_rst_fid", {24'd0, frame_id_a}, 32'd1);

        // Single-bin instance with all-ones count.
        foreach (lit6[i]) exp_b.push_back(lit6[i]);
        @(posedge clk); #1; histo_done_b = 1'b1;
        @(posedge clk); #1; histo_done_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b_done_seen", {31'd0, done_b}, 32'd1);
        check("b_cycles", cyc, 32'd9);
        check("b_queue_drained", exp_b.size(), 32'd0);
        check("b_bin_stayed_0", {31'd0, bin_b_bad}, 32'd0);
        @(posedge clk); #1;
        check("b_fid", {24'd0, frame_id_b}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
